// File: rtl/samp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : samp_ctrl_pkg
// Description : Shared types, default parameters and helper function for the
//               samp_ctrl_gen sample-rate controller.
// Revision    : 1.0 - initial release
// ============================================================================
package samp_ctrl_pkg;

    // Default parameter values
    localparam int DEF_NUM_MODES = 5;
    localparam int DEF_MODE_W    = 3;
    localparam int DEF_DIV_BASE  = 10;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_READY_DLY = 80;

    // Kinds of mode-change request waiting for the next sample boundary
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_UP   = 2'd1,
        REQ_DOWN = 2'd2,
        REQ_LOAD = 2'd3
    } req_t;

    // base^k, evaluated at elaboration to build the period table
    function automatic longint unsigned period_of(input int unsigned k,
                                                  input int unsigned base);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < k; i++) begin
            p = p * 64'(base);
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge_det
// Description : Rising-edge detector for a debounced, synchronous button
//               level. A held button yields a single one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge_det
    import samp_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic btn_q;

    // Remember last cycle's button level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn;
        end
    end

    assign rise = btn & ~btn_q;

endmodule
`default_nettype wire

// File: rtl/samp_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module      : samp_ctrl_gen
// Description : Sample-rate controller. Generates a sticky power-up Ready
//               flag and a periodic one-cycle Enable strobe whose period is
//               DIV_BASE^Mode cycles. Mode is stepped by buttons or loaded
//               directly; changes take effect only on a sample boundary.
//               Optional macro SAMP_ENABLE_GATE_EN: hold the period counter
//               and Enable at zero until Ready is set.
// Revision    : 1.0 - initial release
// ============================================================================
module samp_ctrl_gen
    import samp_ctrl_pkg::*;
#(
    parameter int NUM_MODES = DEF_NUM_MODES,
    parameter int MODE_W    = DEF_MODE_W,
    parameter int DIV_BASE  = DEF_DIV_BASE,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int READY_DLY = DEF_READY_DLY
)(
    input  logic              Fg_CLK,
    input  logic              RESETn,
    input  logic              IntBTN,
    input  logic              DecBTN,
    input  logic              ModeLd,
    input  logic [MODE_W-1:0] ModeLdVal,
    output logic              Ready,
    output logic              Enable,
    output logic [MODE_W-1:0] Mode,
    output logic              ModeChg
);

    localparam int                RDY_W    = $clog2(READY_DLY + 1);
    localparam int                TBL_N    = 2 ** MODE_W;
    localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);
    localparam logic [RDY_W-1:0]  RDY_LAST = RDY_W'(READY_DLY - 1);

    // Reject parameter sets the counter or mode field cannot represent
    generate
        if (NUM_MODES < 2 || NUM_MODES > 8) begin : g_bad_num_modes
            $error("samp_ctrl_gen: NUM_MODES must be 2..8");
        end
        if ((2 ** MODE_W) < NUM_MODES) begin : g_bad_mode_w
            $error("samp_ctrl_gen: MODE_W too narrow for NUM_MODES");
        end
        if (period_of(NUM_MODES - 1, DIV_BASE) > (64'd1 << CNT_W)) begin : g_bad_cnt_w
            $error("samp_ctrl_gen: CNT_W too narrow for longest period");
        end
        if (READY_DLY < 1) begin : g_bad_ready_dly
            $error("samp_ctrl_gen: READY_DLY must be >= 1");
        end
    endgenerate

    // Terminal-count table; unused codes above NUM_MODES-1 reuse the last period
    logic [CNT_W-1:0] period_m1_tbl [TBL_N];

    generate
        for (genvar k = 0; k < TBL_N; k++) begin : g_period_tbl
            localparam int K_EFF = (k < NUM_MODES) ? k : (NUM_MODES - 1);
            assign period_m1_tbl[k] = CNT_W'(period_of(K_EFF, DIV_BASE) - 64'd1);
        end
    endgenerate

    logic              inc_rise;
    logic              dec_rise;
    logic [RDY_W-1:0]  rdy_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period_m1;
    logic              boundary;
    logic              run;
    logic              apply;
    req_t              pend_type;
    req_t              new_type;
    logic [MODE_W-1:0] pend_val;
    logic [MODE_W-1:0] new_val;
    logic [MODE_W-1:0] mode_next;

    btn_edge_det u_inc_edge (
        .clk   (Fg_CLK),
        .rst_n (RESETn),
        .btn   (IntBTN),
        .rise  (inc_rise)
    );

    btn_edge_det u_dec_edge (
        .clk   (Fg_CLK),
        .rst_n (RESETn),
        .btn   (DecBTN),
        .rise  (dec_rise)
    );

`ifdef SAMP_ENABLE_GATE_EN
    assign run = Ready;
`else
    assign run = 1'b1;
`endif

    // Decode this cycle's request and the mode a pending request would produce
    always_comb begin
        period_m1 = period_m1_tbl[Mode];
        boundary  = (cnt == period_m1);
        apply     = run && boundary && (pend_type != REQ_NONE);
        new_type  = REQ_NONE;
        new_val   = (ModeLdVal > MODE_MAX) ? MODE_MAX : ModeLdVal;
        if (Ready) begin
            if (ModeLd) begin
                new_type = REQ_LOAD;
            end else if (inc_rise && !dec_rise) begin
                new_type = REQ_UP;
            end else if (dec_rise && !inc_rise) begin
                new_type = REQ_DOWN;
            end
        end
        case (pend_type)
            REQ_UP:   mode_next = (Mode == MODE_MAX) ? '0 : (Mode + MODE_W'(1));
            REQ_DOWN: mode_next = (Mode == '0) ? MODE_MAX : (Mode - MODE_W'(1));
            default:  mode_next = pend_val;
        endcase
    end

    // Power-up delay: count edges after reset release, then set Ready and stop
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            rdy_cnt <= '0;
            Ready   <= 1'b0;
        end else if (!Ready) begin
            if (rdy_cnt == RDY_LAST) begin
                Ready <= 1'b1;
            end else begin
                rdy_cnt <= rdy_cnt + RDY_W'(1);
            end
        end
    end

    // Period counter, Enable strobe and boundary-aligned mode update
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt     <= '0;
            Enable  <= 1'b0;
            Mode    <= '0;
            ModeChg <= 1'b0;
        end else begin
            ModeChg <= 1'b0;
            if (!run) begin
                cnt    <= '0;
                Enable <= 1'b0;
            end else if (boundary) begin
                cnt    <= '0;
                Enable <= 1'b1;
                if (apply) begin
                    Mode    <= mode_next;
                    ModeChg <= 1'b1;
                end
            end else begin
                cnt    <= cnt + CNT_W'(1);
                Enable <= 1'b0;
            end
        end
    end

    // Pending request: newest request wins, otherwise cleared once applied
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            pend_type <= REQ_NONE;
            pend_val  <= '0;
        end else if (new_type != REQ_NONE) begin
            pend_type <= new_type;
            pend_val  <= new_val;
        end else if (apply) begin
            pend_type <= REQ_NONE;
        end
    end

endmodule
`default_nettype wire
